mii_nibble_rx: RTL

MII receive front end for the mii2mii bridge. Oversamples a PHY's MII receive interface (`mii_clk`, `mii_en`, `mii_d`) in the system clock domain, strips preamble/SFD, and assembles nibbles into bytes. Each byte is presented as `q` with a one-cycle `rdy` strobe, with frame start, end and error flags. Sits directly upstream of the byte FIFO/UART path and drives `rdy`/`q` exactly as that path consumes them.

---
 rtl/mii_nibble_rx_if.sv | 18 +
 rtl/mii_nibble_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mii_nibble_rx_if.sv
// MII receive pins plus the received-byte outputs of mii_nibble_rx.
interface mii_nibble_rx_if;
  logic        mii_clk;
  logic        mii_en;
  logic [3:0]  mii_d;
  logic        rdy;
  logic [7:0]  q;
  logic        sof;
  logic        eof;
  logic        error;
  logic [10:0] len;
  logic        crc_ok;

  modport master (output mii_clk, mii_en, mii_d,
                  input  rdy, q, sof, eof, error, len, crc_ok);
  modport slave  (input  mii_clk, mii_en, mii_d,
                  output rdy, q, sof, eof, error, len, crc_ok);
endinterface

// File: rtl/mii_nibble_rx.sv
// MII RX front end: oversamples RX_CLK/RX_DV/RXD, strips preamble/SFD, emits bytes with sof/eof/error/len.
// 4 clk from RX_CLK fall to rdy; no backpressure (rdy is a strobe). MII_RX_CRC_EN builds the CRC-32 check.
module mii_nibble_rx #(
  parameter int MAX_LEN = 1522
) (
  input  logic           clk,
  input  logic           reset,
  mii_nibble_rx_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_IDLE, IDLE, PREAMBLE, DATA, DROP
  } state_t;

  logic        mclk_s1_q, mclk_s1_d, mclk_s2_q, mclk_s2_d, mclk_prev_q, mclk_prev_d;
  logic        en_s1_q, en_s1_d, en_s2_q, en_s2_d;
  logic [3:0]  d_s1_q, d_s1_d, d_s2_q, d_s2_d;
  logic        stb_q, stb_d, en_q, en_d;
  logic [3:0]  dat_q, dat_d;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [3:0]  lo_q, lo_d;
  logic [10:0] count_q, count_d;
  logic        rdy_q, rdy_d, sof_q, sof_d, eof_q, eof_d, error_q, error_d;
  logic [7:0]  q_q, q_d;
  logic [10:0] len_q, len_d;
  logic [7:0]  rx_byte;

`ifdef MII_RX_CRC_EN
  logic [31:0] crc_q, crc_d;
  logic        crc_ok_q, crc_ok_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ (((r[0] ^ b[i]) != 1'b0) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction
`endif

  // Equal-depth synchronizers; the edge stage keeps en/d aligned with the strobe.
  always_comb begin
    mclk_s1_d   = bus.mii_clk;
    mclk_s2_d   = mclk_s1_q;
    mclk_prev_d = mclk_s2_q;
    en_s1_d     = bus.mii_en;
    en_s2_d     = en_s1_q;
    d_s1_d      = bus.mii_d;
    d_s2_d      = d_s1_q;
    stb_d       = mclk_prev_q & ~mclk_s2_q;
    en_d        = en_s2_q;
    dat_d       = d_s2_q;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    lo_d    = lo_q;
    count_d = count_q;
    rdy_d   = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    q_d     = q_q;
    error_d = error_q;
    len_d   = len_q;
    rx_byte = {dat_q, lo_q};
`ifdef MII_RX_CRC_EN
    crc_d    = crc_q;
    crc_ok_d = crc_ok_q;
`endif
    if (stb_q) begin
      case (state_q)
        WAIT_IDLE: if (!en_q) state_d = IDLE;
        IDLE: begin
          if (en_q) begin
            if (dat_q == 4'h5) state_d = PREAMBLE;
            else begin
              error_d = 1'b1;
              state_d = DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!en_q) state_d = IDLE;
          else if (dat_q == 4'hD) begin
            state_d = DATA;
            phase_d = 1'b0;
            count_d = '0;
`ifdef MII_RX_CRC_EN
            crc_d   = 32'hFFFFFFFF;
`endif
          end else if (dat_q != 4'h5) begin
            error_d = 1'b1;
            state_d = DROP;
          end
        end
        DATA: begin
          if (!en_q) begin
            state_d = IDLE;
            eof_d   = 1'b1;
            len_d   = count_q;
            if (phase_q) error_d = 1'b1;
            if ({21'd0, count_q} > MAX_LEN) error_d = 1'b1;
`ifdef MII_RX_CRC_EN
            crc_ok_d = (crc_q == 32'hDEBB20E3);
            if (crc_q != 32'hDEBB20E3) error_d = 1'b1;
`endif
          end else if (!phase_q) begin
            lo_d    = dat_q;
            phase_d = 1'b1;
          end else begin
            q_d     = rx_byte;
            rdy_d   = 1'b1;
            phase_d = 1'b0;
            // The first byte opens a new frame, so it also retires the previous frame's error.
            if (count_q == 11'd0) begin
              sof_d   = 1'b1;
              error_d = 1'b0;
            end
            if (count_q != 11'h7FF) count_d = count_q + 11'd1;
`ifdef MII_RX_CRC_EN
            crc_d = crc_byte(crc_q, rx_byte);
`endif
          end
        end
        DROP: begin
          if (!en_q) begin
            state_d = IDLE;
            eof_d   = 1'b1;
            len_d   = count_q;
`ifdef MII_RX_CRC_EN
            crc_ok_d = 1'b0;
`endif
          end
        end
        default: state_d = WAIT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mclk_s1_q   <= 1'b0;
      mclk_s2_q   <= 1'b0;
      mclk_prev_q <= 1'b0;
      en_s1_q     <= 1'b0;
      en_s2_q     <= 1'b0;
      d_s1_q      <= 4'd0;
      d_s2_q      <= 4'd0;
      stb_q       <= 1'b0;
      en_q        <= 1'b0;
      dat_q       <= 4'd0;
      state_q     <= WAIT_IDLE;
      phase_q     <= 1'b0;
      lo_q        <= 4'd0;
      count_q     <= 11'd0;
      rdy_q       <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      q_q         <= 8'd0;
      error_q     <= 1'b0;
      len_q       <= 11'd0;
`ifdef MII_RX_CRC_EN
      crc_q       <= 32'd0;
      crc_ok_q    <= 1'b0;
`endif
    end else begin
      mclk_s1_q   <= mclk_s1_d;
      mclk_s2_q   <= mclk_s2_d;
      mclk_prev_q <= mclk_prev_d;
      en_s1_q     <= en_s1_d;
      en_s2_q     <= en_s2_d;
      d_s1_q      <= d_s1_d;
      d_s2_q      <= d_s2_d;
      stb_q       <= stb_d;
      en_q        <= en_d;
      dat_q       <= dat_d;
      state_q     <= state_d;
      phase_q     <= phase_d;
      lo_q        <= lo_d;
      count_q     <= count_d;
      rdy_q       <= rdy_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      q_q         <= q_d;
      error_q     <= error_d;
      len_q       <= len_d;
`ifdef MII_RX_CRC_EN
      crc_q       <= crc_d;
      crc_ok_q    <= crc_ok_d;
`endif
    end
  end

  assign bus.rdy   = rdy_q;
  assign bus.q     = q_q;
  assign bus.sof   = sof_q;
  assign bus.eof   = eof_q;
  assign bus.error = error_q;
  assign bus.len   = len_q;
`ifdef MII_RX_CRC_EN
  assign bus.crc_ok = crc_ok_q;
`else
  assign bus.crc_ok = 1'b0;
`endif

endmodule
